scan_pq: RTL

- Device-side (responder) priority queue for the pq_if protocol; the other end of the client FSM that drives enq/deq/kvi and reads kvo.
- Unsorted register array: O(1) enqueue; after each dequeue, a sequential min-scan of one entry per cycle while busy is high.
- Drops in beside the existing PQ implementations behind the pq_if dev modport. A thin wrapper maps the interface signals onto the flat ports below.

---
 rtl/pq_pkg.sv | 24 ++
 rtl/scan_pq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pq_pkg.sv
// Shared types for the priority-queue family: the key/value entry, the
// responder FSM states and the unsigned strict key comparison.
package pq_pkg;

  localparam int KEY_W = 8;
  localparam int VAL_W = 8;
  localparam int KV_W  = KEY_W + VAL_W;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] value;
  } kv_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } pq_state_e;

  // Strict so that an equal key never displaces an earlier entry.
  function automatic logic kv_less(input kv_t a, input kv_t b);
    return a.key < b.key;
  endfunction

endpackage

// File: rtl/scan_pq.sv
// Unsorted-array priority queue: O(1) enqueue, and after every dequeue or
// replace a one-entry-per-cycle min-scan rebuilds the head while busy is high.
module scan_pq
  import pq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enq,
  input  logic            deq,
  input  logic [KV_W-1:0] kvi,
  output logic [KV_W-1:0] kvo,
  output logic            full,
  output logic            empty,
  output logic            busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pq_state_e      state_q,    state_d;
  logic [CW-1:0]  count_q,    count_d;
  logic [CW-1:0]  scan_idx_q, scan_idx_d;
  logic [IW-1:0]  min_idx_q,  min_idx_d;
  logic [IW-1:0]  best_idx_q, best_idx_d;
  kv_t            kvo_q,      kvo_d;
  kv_t            best_q,     best_d;
  logic           full_q,     empty_q;

  kv_t            mem [DEPTH];
  logic           mem_we;
  logic [IW-1:0]  mem_waddr;
  kv_t            mem_wdata;

  kv_t            kv_in;
  kv_t            scan_kv;
  kv_t            cand;
  logic [IW-1:0]  cand_idx;
  logic           do_enq, do_deq, do_repl;

  assign kv_in   = kv_t'(kvi);
  assign scan_kv = mem[IW'(scan_idx_q)];

  // A replace needs a non-empty queue; enq+deq on an empty queue is a plain enq.
  assign do_repl = enq && deq && !empty_q;
  assign do_enq  = enq && !do_repl && !full_q;
  assign do_deq  = deq && !enq && !empty_q;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    scan_idx_d = scan_idx_q;
    min_idx_d  = min_idx_q;
    best_idx_d = best_idx_q;
    kvo_d      = kvo_q;
    best_d     = best_q;
    mem_we     = 1'b0;
    mem_waddr  = min_idx_q;
    mem_wdata  = kv_in;
    cand       = best_q;
    cand_idx   = best_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (do_enq) begin
          mem_we    = 1'b1;
          mem_waddr = count_q[IW-1:0];
          count_d   = count_q + CW'(1);
          if (empty_q || kv_less(kv_in, kvo_q)) begin
            kvo_d     = kv_in;
            min_idx_d = count_q[IW-1:0];
          end
        end else if (do_deq) begin
          // Move the last entry into the hole left by the popped head.
          mem_we    = 1'b1;
          mem_wdata = mem[IW'(count_q - CW'(1))];
          count_d   = count_q - CW'(1);
          if (count_d == '0) begin
            kvo_d     = '0;
            min_idx_d = '0;
          end else begin
            state_d    = ST_SCAN;
            scan_idx_d = '0;
          end
        end else if (do_repl) begin
          mem_we     = 1'b1;
          state_d    = ST_SCAN;
          scan_idx_d = '0;
        end
      end

      ST_SCAN: begin
        if (scan_idx_q == '0 || kv_less(scan_kv, best_q)) begin
          cand     = scan_kv;
          cand_idx = IW'(scan_idx_q);
        end
        if (scan_idx_q == count_q - CW'(1)) begin
          kvo_d     = cand;
          min_idx_d = cand_idx;
          state_d   = ST_IDLE;
        end else begin
          best_d     = cand;
          best_idx_d = cand_idx;
          scan_idx_d = scan_idx_q + CW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      scan_idx_q <= '0;
      min_idx_q  <= '0;
      best_idx_q <= '0;
      kvo_q      <= '0;
      best_q     <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      scan_idx_q <= scan_idx_d;
      min_idx_q  <= min_idx_d;
      best_idx_q <= best_idx_d;
      kvo_q      <= kvo_d;
      best_q     <= best_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == '0);
    end
  end

  // NOTE: the storage array has no reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign kvo   = kvo_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign busy  = (state_q == ST_SCAN);

endmodule
